// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS core: opcodes, ALU op codes and
// the layout of the 11-bit decoded control bundle carried down the pipeline.
package cpu_pkg;

    localparam int REG_W   = 5;
    localparam int FUNCT_W = 6;
    localparam int ALUOP_W = 3;
    localparam int CTRL_W  = 11;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BGEZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGT   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'd4;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'd5;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'd6;
    localparam logic [ALUOP_W-1:0] ALU_BGT   = 3'd7;

    // Bit positions inside the control bundle; aluop occupies the low three bits.
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_MEMREAD   = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_JUMP      = 6;
    localparam int CTRL_BRANCH    = 7;
    localparam int CTRL_REGDST    = 8;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_REGWRITE  = 10;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic ctrl_t make_ctrl(
        input logic               regwrite,
        input logic               alusrc,
        input logic               regdst,
        input logic               branch,
        input logic               jump,
        input logic               memwrite,
        input logic               memread,
        input logic               memtoreg,
        input logic [ALUOP_W-1:0] aluop
    );
        ctrl_t c;
        c                                   = '0;
        c[CTRL_REGWRITE]                    = regwrite;
        c[CTRL_ALUSRC]                      = alusrc;
        c[CTRL_REGDST]                      = regdst;
        c[CTRL_BRANCH]                      = branch;
        c[CTRL_JUMP]                        = jump;
        c[CTRL_MEMWRITE]                    = memwrite;
        c[CTRL_MEMREAD]                     = memread;
        c[CTRL_MEMTOREG]                    = memtoreg;
        c[CTRL_ALUOP_LSB +: ALUOP_W]        = aluop;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a stall, unless that ID instruction is being flushed.
import cpu_pkg::*;

module hazard_detect (
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             flush_i,
    output logic             hazard_o,
    output logic             stall_o
);

    logic w_rt_nonzero;
    logic w_rt_match;

    // Writes to $0 are discarded, so a load targeting $0 never creates a dependency.
    assign w_rt_nonzero = (ex_rt_i != '0);
    assign w_rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);

    assign hazard_o = ex_valid_i & ex_memread_i & id_valid_i & w_rt_nonzero & w_rt_match;
    assign stall_o  = hazard_o & ~flush_i;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: captures decoded control and operands for EX,
// turning flushed, stalled or empty slots into bubbles and counting load-use stalls.
import cpu_pkg::*;

module id_ex_pipe #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               id_valid_i,
    input  logic               id_regwrite_i,
    input  logic               id_alusrc_i,
    input  logic               id_regdst_i,
    input  logic               id_branch_i,
    input  logic               id_jump_i,
    input  logic               id_memwrite_i,
    input  logic               id_memread_i,
    input  logic               id_memtoreg_i,
    input  logic [ALUOP_W-1:0] id_aluop_i,
    input  logic [DW-1:0]      id_pc4_i,
    input  logic [DW-1:0]      id_rs_data_i,
    input  logic [DW-1:0]      id_rt_data_i,
    input  logic [DW-1:0]      id_imm_i,
    input  logic [REG_W-1:0]   id_rs_i,
    input  logic [REG_W-1:0]   id_rt_i,
    input  logic [REG_W-1:0]   id_rd_i,
    input  logic [FUNCT_W-1:0] id_funct_i,
    input  logic               flush_i,
    output logic               ex_valid_o,
    output logic               ex_regwrite_o,
    output logic               ex_alusrc_o,
    output logic               ex_regdst_o,
    output logic               ex_branch_o,
    output logic               ex_jump_o,
    output logic               ex_memwrite_o,
    output logic               ex_memread_o,
    output logic               ex_memtoreg_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [DW-1:0]      ex_pc4_o,
    output logic [DW-1:0]      ex_rs_data_o,
    output logic [DW-1:0]      ex_rt_data_o,
    output logic [DW-1:0]      ex_imm_o,
    output logic [REG_W-1:0]   ex_rs_o,
    output logic [REG_W-1:0]   ex_rt_o,
    output logic [REG_W-1:0]   ex_rd_o,
    output logic [FUNCT_W-1:0] ex_funct_o,
    output logic               stall_o,
    output logic [CNTW-1:0]    hazard_cnt_o
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    ctrl_t              r_ctrl;
    logic               r_valid;
    logic [DW-1:0]      r_pc4;
    logic [DW-1:0]      r_rs_data;
    logic [DW-1:0]      r_rt_data;
    logic [DW-1:0]      r_imm;
    logic [REG_W-1:0]   r_rs;
    logic [REG_W-1:0]   r_rt;
    logic [REG_W-1:0]   r_rd;
    logic [FUNCT_W-1:0] r_funct;
    logic [CNTW-1:0]    r_hazard_cnt;

    ctrl_t w_id_ctrl;
    logic  w_hazard;
    logic  w_stall;
    logic  w_bubble;

    assign w_id_ctrl = make_ctrl(id_regwrite_i, id_alusrc_i, id_regdst_i, id_branch_i,
                                 id_jump_i, id_memwrite_i, id_memread_i, id_memtoreg_i,
                                 id_aluop_i);

    hazard_detect u_hazard_detect (
        .ex_valid_i   (r_valid),
        .ex_memread_i (r_ctrl[CTRL_MEMREAD]),
        .ex_rt_i      (r_rt),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .flush_i      (flush_i),
        .hazard_o     (w_hazard),
        .stall_o      (w_stall)
    );

    // Flush and hazard both squash the slot; they differ only in whether the front end holds.
    assign w_bubble = flush_i | w_hazard | ~id_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else if (w_bubble) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= w_id_ctrl;
            r_valid <= 1'b1;
        end
    end

    // Operand fields are don't-care on a bubble, so they load every cycle without gating.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_funct   <= '0;
        end else begin
            r_pc4     <= id_pc4_i;
            r_rs_data <= id_rs_data_i;
            r_rt_data <= id_rt_data_i;
            r_imm     <= id_imm_i;
            r_rs      <= id_rs_i;
            r_rt      <= id_rt_i;
            r_rd      <= id_rd_i;
            r_funct   <= id_funct_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hazard_cnt <= '0;
        end else if (w_stall && (r_hazard_cnt != CNT_MAX)) begin
            r_hazard_cnt <= r_hazard_cnt + CNT_ONE;
        end
    end

    assign ex_valid_o    = r_valid;
    assign ex_regwrite_o = r_ctrl[CTRL_REGWRITE];
    assign ex_alusrc_o   = r_ctrl[CTRL_ALUSRC];
    assign ex_regdst_o   = r_ctrl[CTRL_REGDST];
    assign ex_branch_o   = r_ctrl[CTRL_BRANCH];
    assign ex_jump_o     = r_ctrl[CTRL_JUMP];
    assign ex_memwrite_o = r_ctrl[CTRL_MEMWRITE];
    assign ex_memread_o  = r_ctrl[CTRL_MEMREAD];
    assign ex_memtoreg_o = r_ctrl[CTRL_MEMTOREG];
    assign ex_aluop_o    = r_ctrl[CTRL_ALUOP_LSB +: ALUOP_W];
    assign ex_pc4_o      = r_pc4;
    assign ex_rs_data_o  = r_rs_data;
    assign ex_rt_data_o  = r_rt_data;
    assign ex_imm_o      = r_imm;
    assign ex_rs_o       = r_rs;
    assign ex_rt_o       = r_rt;
    assign ex_rd_o       = r_rd;
    assign ex_funct_o    = r_funct;
    assign stall_o       = w_stall;
    assign hazard_cnt_o  = r_hazard_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: a reference model pushes expected EX
// state into a scoreboard queue as each ID instruction is driven.
module tb_id_ex_pipe;

    localparam int DW   = 32;
    localparam int CNTW = 2;
    localparam logic [CNTW-1:0] CNT_SAT = '1;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          alusrc;
        logic          regdst;
        logic          branch;
        logic          jump;
        logic          memwrite;
        logic          memread;
        logic          memtoreg;
        logic [2:0]    aluop;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rsData;
        logic [DW-1:0] rtData;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [5:0]    funct;
    } instr_t;

    typedef struct packed {
        logic            valid;
        logic [10:0]     ctrl;
        logic [DW-1:0]   pc4;
        logic [DW-1:0]   rsData;
        logic [DW-1:0]   rtData;
        logic [DW-1:0]   imm;
        logic [14:0]     regs;
        logic [5:0]      funct;
        logic [CNTW-1:0] cnt;
    } expect_t;

    logic clock;
    logic reset;
    logic flush;
    instr_t cur;

    logic            exValid, exRegwrite, exAlusrc, exRegdst, exBranch, exJump;
    logic            exMemwrite, exMemread, exMemtoreg;
    logic [2:0]      exAluop;
    logic [DW-1:0]   exPc4, exRsData, exRtData, exImm;
    logic [4:0]      exRs, exRt, exRd;
    logic [5:0]      exFunct;
    logic            stall;
    logic [CNTW-1:0] hazardCnt;

    int compareCount;
    int mismatchCount;

    expect_t scoreboard[$];

    logic            mValid;
    logic            mMemread;
    logic [4:0]      mRt;
    logic [CNTW-1:0] mCnt;

    id_ex_pipe #(.DW(DW), .CNTW(CNTW)) dut (
        .clk_i         (clock),
        .rst_i         (reset),
        .id_valid_i    (cur.valid),
        .id_regwrite_i (cur.regwrite),
        .id_alusrc_i   (cur.alusrc),
        .id_regdst_i   (cur.regdst),
        .id_branch_i   (cur.branch),
        .id_jump_i     (cur.jump),
        .id_memwrite_i (cur.memwrite),
        .id_memread_i  (cur.memread),
        .id_memtoreg_i (cur.memtoreg),
        .id_aluop_i    (cur.aluop),
        .id_pc4_i      (cur.pc4),
        .id_rs_data_i  (cur.rsData),
        .id_rt_data_i  (cur.rtData),
        .id_imm_i      (cur.imm),
        .id_rs_i       (cur.rs),
        .id_rt_i       (cur.rt),
        .id_rd_i       (cur.rd),
        .id_funct_i    (cur.funct),
        .flush_i       (flush),
        .ex_valid_o    (exValid),
        .ex_regwrite_o (exRegwrite),
        .ex_alusrc_o   (exAlusrc),
        .ex_regdst_o   (exRegdst),
        .ex_branch_o   (exBranch),
        .ex_jump_o     (exJump),
        .ex_memwrite_o (exMemwrite),
        .ex_memread_o  (exMemread),
        .ex_memtoreg_o (exMemtoreg),
        .ex_aluop_o    (exAluop),
        .ex_pc4_o      (exPc4),
        .ex_rs_data_o  (exRsData),
        .ex_rt_data_o  (exRtData),
        .ex_imm_o      (exImm),
        .ex_rs_o       (exRs),
        .ex_rt_o       (exRt),
        .ex_rd_o       (exRd),
        .ex_funct_o    (exFunct),
        .stall_o       (stall),
        .hazard_cnt_o  (hazardCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic instr_t mkAdd(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [DW-1:0] pc4);
        instr_t i = '0;
        i.valid = 1'b1; i.regwrite = 1'b1; i.regdst = 1'b1; i.aluop = 3'd2;
        i.pc4 = pc4; i.rsData = 32'h1000_0000 | DW'(rs); i.rtData = 32'h2000_0000 | DW'(rt);
        i.rs = rs; i.rt = rt; i.rd = rd; i.funct = 6'h20;
        return i;
    endfunction

    function automatic instr_t mkLw(input logic [4:0] rs, input logic [4:0] rt, input logic [DW-1:0] pc4);
        instr_t i = '0;
        i.valid = 1'b1; i.regwrite = 1'b1; i.alusrc = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1;
        i.pc4 = pc4; i.rsData = 32'hA5A5_0000 | DW'(rs); i.imm = 32'hFFFF_FFF8;
        i.rs = rs; i.rt = rt; i.rd = 5'd0; i.funct = 6'h38;
        return i;
    endfunction

    function automatic instr_t mkBeq(input logic [4:0] rs, input logic [4:0] rt, input logic [DW-1:0] pc4);
        instr_t i = '0;
        i.valid = 1'b1; i.branch = 1'b1; i.aluop = 3'd1;
        i.pc4 = pc4; i.rsData = 32'h0BAD_0001; i.rtData = 32'h0BAD_0001; i.imm = 32'h0000_0010;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic logic [10:0] packCtrl(input instr_t i);
        return {i.regwrite, i.alusrc, i.regdst, i.branch, i.jump, i.memwrite, i.memread, i.memtoreg, i.aluop};
    endfunction

    task automatic modelReset();
        mValid = 1'b0; mMemread = 1'b0; mRt = 5'd0; mCnt = '0;
    endtask

    // One ID slot: drive at negedge, check stall, push the model's EX prediction,
    // then pop and compare once the rising edge has loaded the register.
    task automatic applyStimulus(input string name, input instr_t ins, input logic doFlush);
        expect_t e, got;
        logic hz, st, bub;
        @(negedge clock);
        cur   = ins;
        flush = doFlush;
        #1;
        hz  = mValid && mMemread && ins.valid && (mRt != 5'd0) && (mRt == ins.rs || mRt == ins.rt);
        st  = hz && !doFlush;
        bub = doFlush || hz || !ins.valid;
        checkOutput({name, ".stall"}, 64'(stall), 64'(st));
        if (st && mCnt != CNT_SAT) mCnt = mCnt + 1'b1;
        e.valid  = !bub;
        e.ctrl   = bub ? 11'd0 : packCtrl(ins);
        e.pc4    = ins.pc4;
        e.rsData = ins.rsData;
        e.rtData = ins.rtData;
        e.imm    = ins.imm;
        e.regs   = {ins.rs, ins.rt, ins.rd};
        e.funct  = ins.funct;
        e.cnt    = mCnt;
        scoreboard.push_back(e);
        mValid   = e.valid;
        mMemread = e.ctrl[4];
        mRt      = ins.rt;
        @(posedge clock);
        #1;
        e = scoreboard.pop_front();
        got.valid  = exValid;
        got.ctrl   = {exRegwrite, exAlusrc, exRegdst, exBranch, exJump, exMemwrite, exMemread, exMemtoreg, exAluop};
        got.pc4    = exPc4;
        got.rsData = exRsData;
        got.rtData = exRtData;
        got.imm    = exImm;
        got.regs   = {exRs, exRt, exRd};
        got.funct  = exFunct;
        got.cnt    = hazardCnt;
        checkOutput({name, ".valid"}, 64'(got.valid), 64'(e.valid));
        checkOutput({name, ".ctrl"},  64'(got.ctrl),  64'(e.ctrl));
        checkOutput({name, ".pc4"},   64'(got.pc4),   64'(e.pc4));
        checkOutput({name, ".data"},  {got.rsData, got.rtData}, {e.rsData, e.rtData});
        checkOutput({name, ".imm"},   64'(got.imm),   64'(e.imm));
        checkOutput({name, ".regs"},  64'({got.regs, got.funct}), 64'({e.regs, e.funct}));
        checkOutput({name, ".cnt"},   64'(got.cnt),   64'(e.cnt));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".valid"}, 64'(exValid), 64'd0);
        checkOutput({name, ".ctrl"},
                    64'({exRegwrite, exAlusrc, exRegdst, exBranch, exJump, exMemwrite, exMemread, exMemtoreg, exAluop}), 64'd0);
        checkOutput({name, ".data"}, {exPc4, exRsData}, 64'd0);
        checkOutput({name, ".data2"}, {exRtData, exImm}, 64'd0);
        checkOutput({name, ".regs"}, 64'({exRs, exRt, exRd, exFunct}), 64'd0);
        checkOutput({name, ".stall"}, 64'(stall), 64'd0);
        checkOutput({name, ".cnt"}, 64'(hazardCnt), 64'd0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        cur   = '0;
        flush = 1'b0;
        reset = 1'b1;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("initReset");
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] pass-through");
        applyStimulus("addPass", mkAdd(5'd1, 5'd2, 5'd3, 32'h0000_0104), 1'b0);
        applyStimulus("idle", '0, 1'b0);

        $display("[TB] load-use stall");
        applyStimulus("lw5", mkLw(5'd1, 5'd5, 32'h0000_0200), 1'b0);
        applyStimulus("useStall", mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0204), 1'b0);
        applyStimulus("useLoad", mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0204), 1'b0);

        $display("[TB] no false hazards");
        applyStimulus("lw0", mkLw(5'd1, 5'd0, 32'h0000_0300), 1'b0);
        applyStimulus("use0", mkAdd(5'd0, 5'd0, 5'd6, 32'h0000_0304), 1'b0);
        applyStimulus("lw5b", mkLw(5'd1, 5'd5, 32'h0000_0308), 1'b0);
        applyStimulus("indep", mkAdd(5'd1, 5'd2, 5'd6, 32'h0000_030C), 1'b0);

        $display("[TB] back-to-back loads");
        applyStimulus("lwA", mkLw(5'd2, 5'd5, 32'h0000_0400), 1'b0);
        applyStimulus("lwBStall", mkLw(5'd5, 5'd8, 32'h0000_0404), 1'b0);
        applyStimulus("lwBLoad", mkLw(5'd5, 5'd8, 32'h0000_0404), 1'b0);

        $display("[TB] flush");
        applyStimulus("beqFlush", mkBeq(5'd1, 5'd2, 32'h0000_0500), 1'b1);
        applyStimulus("lwC", mkLw(5'd1, 5'd9, 32'h0000_0504), 1'b0);
        applyStimulus("flushHaz", mkAdd(5'd9, 5'd3, 5'd4, 32'h0000_0508), 1'b1);
        applyStimulus("afterFlush", mkAdd(5'd9, 5'd3, 5'd4, 32'h0000_050C), 1'b0);

        $display("[TB] reset mid-stall");
        applyStimulus("lwD", mkLw(5'd1, 5'd5, 32'h0000_0600), 1'b0);
        @(negedge clock);
        cur = mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0604);
        #1;
        checkOutput("preReset.stall", 64'(stall), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("midReset");
        modelReset();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus("postReset", mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0604), 1'b0);

        $display("[TB] counter saturation");
        for (int k = 0; k < 5; k++) begin
            applyStimulus("satLw", mkLw(5'd1, 5'd5, 32'h0000_0700 + DW'(k * 16)), 1'b0);
            applyStimulus("satStall", mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0704 + DW'(k * 16)), 1'b0);
            applyStimulus("satLoad", mkAdd(5'd5, 5'd7, 5'd6, 32'h0000_0704 + DW'(k * 16)), 1'b0);
        end
        checkOutput("satFinal.cnt", 64'(hazardCnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
